uart_rx_edge_bit_timer: RTL and testbench

Parametrised oversampling timer for the UART receiver; generalises the RX edge/bit counter. It counts oversampling edges within each bit and counts bits within a frame. It emits three mid-bit sample strobes for majority voting, plus bit-end and frame-done pulses, and flags illegal configurations. It sits between the RX FSM (which drives `enable`) and the data/parity/stop samplers and checkers.

---
 rtl/uart_rx_edge_bit_timer.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_edge_bit_timer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_edge_bit_timer.sv
// rtl/uart_rx_edge_bit_timer.sv - oversampling edge/bit timer for the UART receiver
//
// Counts oversampling edges within a bit and bits within a frame, decodes
// three mid-bit sample strobes, a bit-end pulse and a frame-done pulse, and
// flags illegal prescale/frame_bits configurations.
//
// Optional feature macro: EDGE_BIT_RESYNC_EN (resync realigns edge_cnt in RUN).
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   enable         high = frame in progress, low = clear and idle
//   prescale       oversampling ratio (legal 4 .. 2^PRESCALE_W-1)
//   frame_bits     bits per frame incl. start/stop (legal 1 .. 2^BIT_W-1)
//   resync         edge realignment pulse (only with EDGE_BIT_RESYNC_EN)
//   edge_cnt       edge index within the current bit (registered)
//   bit_cnt        bit index within the frame (registered)
//   sample_stb     mid-bit sample strobe
//   sample_idx     which of the three samples is strobed (0..2)
//   bit_end        last edge of the current bit
//   frame_done     last edge of the last bit
//   cfg_err        latched configuration was illegal (registered)

module uart_rx_edge_bit_timer #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [BIT_W-1:0]      frame_bits,
  input  logic                  resync,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]      bit_cnt,
  output logic                  sample_stb,
  output logic [1:0]            sample_idx,
  output logic                  bit_end,
  output logic                  frame_done,
  output logic                  cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [BIT_W-1:0]      frame_bits_q;
  logic [PRESCALE_W-1:0] edge_cnt_q;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic                  cfg_err_q;

  logic                  cfg_legal;
  logic                  resync_eff;
  logic [PRESCALE_W-1:0] edge_last;
  logic [PRESCALE_W-1:0] mid;
  logic [PRESCALE_W-1:0] idx_full;
  logic                  at_last;

`ifdef EDGE_BIT_RESYNC_EN
  assign resync_eff = resync && (state_q == S_RUN);
`else
  // Port kept for a uniform interface; behaves as if tied low.
  logic unused_resync;
  assign unused_resync = resync;
  assign resync_eff    = 1'b0;
`endif

  // Legality is judged on the live inputs because they are only sampled
  // on the IDLE exit cycle.
  assign cfg_legal = (prescale >= PRESCALE_W'(4)) && (frame_bits != '0);
  assign edge_last = prescale_q - PRESCALE_W'(1);
  assign mid       = prescale_q >> 1;
  assign idx_full  = edge_cnt_q - (mid - PRESCALE_W'(1));
  assign at_last   = (edge_cnt_q == edge_last);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; dropping enable overrides everything
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = cfg_legal ? S_RUN : S_ERR;
        S_RUN:   if (frame_done) state_d = S_DONE;
        S_DONE:  state_d = S_DONE;
        S_ERR:   state_d = S_ERR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from registered state and counters
  always_comb begin
    sample_stb = 1'b0;
    sample_idx = 2'd0;
    bit_end    = 1'b0;
    frame_done = 1'b0;
    if (state_q == S_RUN) begin
      sample_stb = (edge_cnt_q >= mid - PRESCALE_W'(1)) &&
                   (edge_cnt_q <= mid + PRESCALE_W'(1));
      if (sample_stb) begin
        sample_idx = idx_full[1:0];
      end
      // A coincident resync restarts the bit, so it never ends here.
      bit_end    = at_last && !resync_eff;
      frame_done = bit_end && (bit_cnt_q == frame_bits_q - BIT_W'(1));
    end
  end

  // Counters, configuration latch and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_q   <= '0;
      frame_bits_q <= '0;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      cfg_err_q    <= 1'b0;
    end else if (!enable) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          prescale_q   <= prescale;
          frame_bits_q <= frame_bits;
          edge_cnt_q   <= '0;
          bit_cnt_q    <= '0;
          cfg_err_q    <= !cfg_legal;
        end
        S_RUN: begin
          if (resync_eff) begin
            edge_cnt_q <= '0;
          end else if (at_last) begin
            // On the final bit this lands bit_cnt on frame_bits_q for DONE.
            edge_cnt_q <= '0;
            bit_cnt_q  <= bit_cnt_q + BIT_W'(1);
          end else begin
            edge_cnt_q <= edge_cnt_q + PRESCALE_W'(1);
          end
        end
        S_DONE: begin
          edge_cnt_q <= '0;
          bit_cnt_q  <= frame_bits_q;
        end
        default: begin
          edge_cnt_q <= '0;
          bit_cnt_q  <= '0;
          cfg_err_q  <= 1'b1;
        end
      endcase
    end
  end

  assign edge_cnt = edge_cnt_q;
  assign bit_cnt  = bit_cnt_q;
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_uart_rx_edge_bit_timer.sv
// tb/tb_uart_rx_edge_bit_timer.sv - self-checking bench for uart_rx_edge_bit_timer

module tb_uart_rx_edge_bit_timer;

  localparam int PW = 6;
  localparam int BW = 4;
`ifdef EDGE_BIT_RESYNC_EN
  localparam bit RS_EN = 1'b1;
`else
  localparam bit RS_EN = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;
  localparam int M_ERR  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [PW-1:0] prescale = '0;
  logic [BW-1:0] frame_bits = '0;
  logic          resync = 1'b0;
  logic [PW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic          sample_stb;
  logic [1:0]    sample_idx;
  logic          bit_end;
  logic          frame_done;
  logic          cfg_err;

  uart_rx_edge_bit_timer #(.PRESCALE_W(PW), .BIT_W(BW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .prescale(prescale),
    .frame_bits(frame_bits), .resync(resync), .edge_cnt(edge_cnt),
    .bit_cnt(bit_cnt), .sample_stb(sample_stb), .sample_idx(sample_idx),
    .bit_end(bit_end), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: a frame is a run of RUN cycles; the position in it is
  // m_t cycles since the last anchor, and bit = m_bb + m_t / p, edge = m_t % p.
  int m_mode = M_IDLE;
  int m_p, m_fb, m_t, m_bb;

  function automatic logic [15:0] exp_vec();
    int e, b, mid, idx;
    logic stb, be, fd, ce;
    e = 0; b = 0; idx = 0; stb = 0; be = 0; fd = 0; ce = 0;
    if (m_mode == M_RUN) begin
      e   = m_t % m_p;
      b   = m_bb + m_t / m_p;
      mid = m_p / 2;
      stb = (e >= mid - 1) && (e <= mid + 1);
      idx = stb ? e - (mid - 1) : 0;
      be  = (e == m_p - 1) && !(RS_EN && resync);
      fd  = be && (b == m_fb - 1);
    end else if (m_mode == M_DONE) begin
      b = m_fb;
    end else if (m_mode == M_ERR) begin
      ce = 1'b1;
    end
    return {e[PW-1:0], b[BW-1:0], stb, idx[1:0], be, fd, ce};
  endfunction

  function automatic logic [15:0] obs_vec();
    return {edge_cnt, bit_cnt, sample_stb, sample_idx, bit_end, frame_done, cfg_err};
  endfunction

  function automatic int m_edge();
    return (m_mode == M_RUN) ? m_t % m_p : 0;
  endfunction

  function automatic int m_bit();
    return (m_mode == M_RUN) ? m_bb + m_t / m_p : 0;
  endfunction

  // Advance one clock and the model with the inputs held during that cycle.
  task automatic step();
    logic [15:0] v;
    v = exp_vec();
    @(posedge clk);
    if (!rst_n || !enable) begin
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (prescale >= 4 && frame_bits >= 1) begin
            m_mode = M_RUN; m_p = prescale; m_fb = frame_bits; m_t = 0; m_bb = 0;
          end else begin
            m_mode = M_ERR;
          end
        end
        M_RUN: begin
          if (RS_EN && resync) begin
            m_bb = m_bb + m_t / m_p;
            m_t  = 0;
          end else if (v[1]) begin
            m_mode = M_DONE;
          end else begin
            m_t++;
          end
        end
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; resync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_vec() !== 16'h0) begin
      n_fail++; $display("FAIL reset: got %h want %h", obs_vec(), 16'h0);
    end
    rst_n = 1'b1;
    m_mode = M_IDLE;
    step();
  endtask

  task automatic test_frame_p8();
    int n_done, n_be, run_cyc, done_at;
    prescale = 8; frame_bits = 10; enable = 1'b1;
    n_done = 0; n_be = 0; run_cyc = 0; done_at = -1;
    for (int i = 0; i < 90; i++) begin
      #1;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL p8 cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (m_mode == M_RUN) run_cyc++;
      if (bit_end) n_be++;
      if (frame_done) begin n_done++; done_at = run_cyc; end
      step();
    end
    n_cmp++;
    if (n_done !== 1 || done_at !== 80) begin
      n_fail++; $display("FAIL p8_done: got %0d pulses at run cycle %0d want 1 at 80", n_done, done_at);
    end
    n_cmp++;
    if (n_be !== 10) begin
      n_fail++; $display("FAIL p8_bit_end: got %0d want 10", n_be);
    end
    n_cmp++;
    if (bit_cnt !== 4'd10 || edge_cnt !== 6'd0) begin
      n_fail++; $display("FAIL p8_hold: got bit %0d edge %0d want 10 0", bit_cnt, edge_cnt);
    end
    enable = 1'b0; step();
  endtask

  task automatic test_p5();
    int n_stb;
    prescale = 5; frame_bits = 4'($urandom_range(1, 15)); enable = 1'b1; n_stb = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL p5 cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (sample_stb && edge_cnt >= 1 && edge_cnt <= 3) n_stb++;
      step();
    end
    n_cmp++;
    if (n_stb < 3) begin
      n_fail++; $display("FAIL p5_stb: got %0d strobes at edges 1..3 want >= 3", n_stb);
    end
    enable = 1'b0; step();
  endtask

  task automatic test_prescale_change();
    prescale = 8; frame_bits = 3; enable = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i == 12) prescale = 16;
      if (i == 30) enable = 1'b0;
      if (i == 31) enable = 1'b1;
      #1;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL pchg cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      step();
    end
    n_cmp++;
    if (m_p !== 16 || edge_cnt !== 6'(m_edge())) begin
      n_fail++; $display("FAIL pchg_new: got edge %0d want %0d (p %0d)", edge_cnt, m_edge(), m_p);
    end
    enable = 1'b0; step();
  endtask

  task automatic test_cfg_err();
    for (int k = 0; k < 2; k++) begin
      prescale   = (k == 0) ? 6'd3 : 6'd8;
      frame_bits = (k == 0) ? 4'd5 : 4'd0;
      enable = 1'b1;
      for (int i = 0; i < 5; i++) begin
        #1;
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++; $display("FAIL cfg%0d cyc %0d: got %h want %h", k, i, obs_vec(), exp_vec());
        end
        step();
      end
      n_cmp++;
      if (cfg_err !== 1'b1 || sample_stb !== 1'b0) begin
        n_fail++; $display("FAIL cfg%0d_set: got err %b stb %b want 1 0", k, cfg_err, sample_stb);
      end
      enable = 1'b0; step();
      n_cmp++;
      if (cfg_err !== 1'b0) begin
        n_fail++; $display("FAIL cfg%0d_clr: got %b want 0", k, cfg_err);
      end
    end
  endtask

  task automatic test_enable_drop();
    int guard;
    prescale = 8; frame_bits = 10; enable = 1'b1; guard = 0;
    step();
    while (!(m_bit() == 4 && m_edge() == 6) && guard < 100) begin
      step(); guard++;
    end
    n_cmp++;
    if (guard >= 100 || edge_cnt !== 6'd6 || bit_cnt !== 4'd4) begin
      n_fail++; $display("FAIL drop_reach: got bit %0d edge %0d want 4 6", bit_cnt, edge_cnt);
    end
    enable = 1'b0; step();
    n_cmp++;
    if (obs_vec() !== exp_vec() || edge_cnt !== 6'd0 || bit_cnt !== 4'd0) begin
      n_fail++; $display("FAIL drop_clear: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_async_reset();
    prescale = 6; frame_bits = 7; enable = 1'b1;
    repeat (15) step();
    #2;
    rst_n = 1'b0;
    #1;
    m_mode = M_IDLE;
    n_cmp++;
    if (obs_vec() !== 16'h0) begin
      n_fail++; $display("FAIL async_rst: got %h want %h", obs_vec(), 16'h0);
    end
    #1;
    rst_n = 1'b1;
    enable = 1'b0; step();
  endtask

  task automatic test_resync();
    int guard;
    prescale = 16; frame_bits = 4; enable = 1'b1; guard = 0;
    step();
    while (m_edge() != 9 && guard < 40) begin step(); guard++; end
    resync = 1'b1;
    #1;
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL rs9_now: got %h want %h", obs_vec(), exp_vec());
    end
    step();
    resync = 1'b0;
    #1;
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL rs9_next: got %h want %h", obs_vec(), exp_vec());
    end
    guard = 0;
    while (m_edge() != 15 && guard < 40) begin step(); guard++; end
    resync = 1'b1;
    #1;
    n_cmp++;
    if (guard >= 40 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL rs15_now: got %h want %h", obs_vec(), exp_vec());
    end
    step();
    resync = 1'b0;
    for (int i = 0; i < 80; i++) begin
      #1;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rs_run cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      step();
    end
    enable = 1'b0; step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 29) == 0) prescale = 6'($urandom_range(0, 20));
      if ($urandom_range(0, 29) == 0) prescale = 6'($urandom_range(21, 63));
      if ($urandom_range(0, 19) == 0) frame_bits = 4'($urandom_range(0, 15));
      resync = ($urandom_range(0, 24) == 0);
      #1;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rand cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      step();
    end
    resync = 1'b0; enable = 1'b0; step();
  endtask

  initial begin
    test_reset();
    test_frame_p8();
    test_p5();
    test_prescale_change();
    test_cfg_err();
    test_enable_drop();
    test_async_reset();
    test_resync();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
